// File: rtl/rshift64_reg_if.sv
// rshift64_reg_if: operand/shift request and registered result bundle for the 64-bit right shifter
// Optional arith port is present only when RSHIFT64_ARITH_EN is defined.
interface rshift64_reg_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int SHIFT_WIDTH = 6
);
    logic                   valid_in;
    logic [DATA_WIDTH-1:0]  operand;
    logic [SHIFT_WIDTH-1:0] shift;
`ifdef RSHIFT64_ARITH_EN
    logic                   arith;
`endif
    logic [DATA_WIDTH-1:0]  result;
    logic                   valid_out;
    logic                   zero;

    modport master (
        output valid_in, operand, shift,
`ifdef RSHIFT64_ARITH_EN
        output arith,
`endif
        input  result, valid_out, zero
    );

    modport slave (
        input  valid_in, operand, shift,
`ifdef RSHIFT64_ARITH_EN
        input  arith,
`endif
        output result, valid_out, zero
    );
endinterface

// File: rtl/rshift64_reg.sv
// rshift64_reg: 64-bit right barrel shifter (six mux ranks) with one registered output stage
// Define RSHIFT64_ARITH_EN to add the arith input selecting sign fill instead of zero fill.
module rshift64_reg (
    input logic             clk,
    input logic             rst,
    rshift64_reg_if.slave   bus
);
    localparam int DATA_WIDTH  = 64;
    localparam int SHIFT_WIDTH = 6;

    logic [DATA_WIDTH-1:0] stage [0:SHIFT_WIDTH];
    logic                  fill;
    logic [DATA_WIDTH-1:0] result;
    logic                  valid_out;
    logic                  zero;

`ifdef RSHIFT64_ARITH_EN
    assign fill = bus.arith & bus.operand[DATA_WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    assign stage[0] = bus.operand;

    // rank k moves every bit down by 2^k when shift[k] is set, filling the top with fill
    for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_rank
        localparam int S = 1 << k;
        assign stage[k+1] = bus.shift[k] ? {{S{fill}}, stage[k][DATA_WIDTH-1:S]} : stage[k];
    end

    // capture on valid_in; otherwise hold result/zero and drop the valid pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            valid_out <= 1'b0;
            zero      <= 1'b1;
        end else begin
            valid_out <= bus.valid_in;
            if (bus.valid_in) begin
                result <= stage[SHIFT_WIDTH];
                zero   <= stage[SHIFT_WIDTH] == '0;
            end
        end
    end

    assign bus.result    = result;
    assign bus.valid_out = valid_out;
    assign bus.zero      = zero;
endmodule

// File: tb/tb_rshift64_reg.sv
// tb_rshift64_reg: directed plus randomized checks of rshift64_reg against a shift-operator model
module tb_rshift64_reg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [63:0] exp_result = 64'h0;
    logic        exp_zero   = 1'b1;
    logic        exp_valid  = 1'b0;

    rshift64_reg_if bus ();

    rshift64_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] ref_shift(input logic [63:0] op, input int sh, input logic ar);
        logic [63:0] y;
        y = op >> sh;
        if (ar && op[63])
            for (int i = 0; i < sh; i++) y[63-i] = 1'b1;
        return y;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".result"}, bus.result, exp_result);
        check({tag, ".zero"}, 64'(bus.zero), 64'(exp_zero));
        check({tag, ".valid"}, 64'(bus.valid_out), 64'(exp_valid));
    endtask

    task automatic step(input string tag, input logic v, input logic [63:0] op, input int sh, input logic ar);
        @(negedge clk);
        bus.valid_in = v;
        bus.operand  = op;
        bus.shift    = v ? 6'(sh) : 6'(~sh);
`ifdef RSHIFT64_ARITH_EN
        bus.arith    = ar;
`endif
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) begin
            exp_result = ref_shift(op, sh, ar);
            exp_zero   = exp_result == 64'h0;
        end
        check_outputs(tag);
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.operand  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.shift    = 6'd0;
`ifdef RSHIFT64_ARITH_EN
        bus.arith    = 1'b0;
`endif
        // asynchronous reset before the first rising edge
        #2 rst = 1'b1;
        #1;
        check("rst_async.result", bus.result, 64'h0);
        check("rst_async.zero", 64'(bus.zero), 64'h1);
        check("rst_async.valid", 64'(bus.valid_out), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        step("sh1_op1", 1'b1, 64'h1, 1, 1'b0);
        check("sh1_op1.lit", bus.result, 64'h0);
        step("sh1_op8", 1'b1, 64'h8, 1, 1'b0);
        check("sh1_op8.lit", bus.result, 64'h4);
        step("sh1_op32", 1'b1, 64'd32, 1, 1'b0);
        check("sh1_op32.lit", bus.result, 64'h10);

        step("msb_sh0", 1'b1, 64'h8000_0000_0000_0000, 0, 1'b0);
        check("msb_sh0.lit", bus.result, 64'h8000_0000_0000_0000);
        step("msb_sh32", 1'b1, 64'h8000_0000_0000_0000, 32, 1'b0);
        check("msb_sh32.lit", bus.result, 64'h0000_0000_8000_0000);
        step("msb_sh63", 1'b1, 64'h8000_0000_0000_0000, 63, 1'b0);
        check("msb_sh63.lit", bus.result, 64'h1);

        step("ones_sh36", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 36, 1'b0);
        check("ones_sh36.lit", bus.result, 64'h0000_0000_0FFF_FFFF);
`ifdef RSHIFT64_ARITH_EN
        step("ones_sh36_arith", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 36, 1'b1);
        check("ones_sh36_arith.lit", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
`endif

        step("hold_cap", 1'b1, 64'h1234, 4, 1'b0);
        check("hold_cap.lit", bus.result, 64'h123);
        step("hold_idle", 1'b0, 64'hDEAD_BEEF_0000_0001, 9, 1'b0);
        check("hold_idle.lit", bus.result, 64'h123);
        check("hold_idle.vlit", 64'(bus.valid_out), 64'h0);

        // reset landing between two captures, with a capture request pending
        step("pre_rst", 1'b1, 64'hABCD_0000, 8, 1'b0);
        #2;
        bus.valid_in = 1'b1;
        bus.operand  = 64'hFFFF;
        bus.shift    = 6'd0;
        rst = 1'b1;
        #1;
        check("mid_rst.result", bus.result, 64'h0);
        check("mid_rst.zero", 64'(bus.zero), 64'h1);
        check("mid_rst.valid", 64'(bus.valid_out), 64'h0);
        @(posedge clk);
        #1;
        check("rst_held.result", bus.result, 64'h0);
        check("rst_held.valid", 64'(bus.valid_out), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        exp_result = 64'h0;
        exp_zero   = 1'b1;
        step("post_rst", 1'b1, 64'hF0, 4, 1'b0);
        check("post_rst.lit", bus.result, 64'hF);

        for (int n = 0; n < 300; n++) begin
            logic [63:0] op;
            logic        v;
            logic        ar;
            int          sh;
            op = {32'($urandom), 32'($urandom)};
            case ($urandom_range(0, 3))
                0: op = op & 64'hFF;
                1: op = op | 64'h8000_0000_0000_0000;
                default: ;
            endcase
            sh = $urandom_range(0, 63);
            v  = $urandom_range(0, 3) != 0;
`ifdef RSHIFT64_ARITH_EN
            ar = 1'($urandom);
`else
            ar = 1'b0;
`endif
            step("rand", v, op, sh, ar);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
